// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the counter-width helper.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // A 1-bit operand still needs a 1-bit counter, so never return zero.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fsbit.sv
// Single-bit full-subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// behind valid/ready handshakes on both the operand and result sides.
import serial_sub_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CNT_W = int'(cnt_width(WIDTH));

    state_t             state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   sd;
    logic [WIDTH-1:0]   sd_next;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;

    full_subtractor_bit u_fsb (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // With a single bit there is nothing to shift down behind the new bit.
    if (WIDTH == 1) begin : g_w1
        assign sd_next = d_bit;
    end else begin : g_wn
        assign sd_next = {d_bit, sd[WIDTH-1:1]};
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sd        <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    br  <= bo_bit;
                    cnt <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff      <= sd_next;
                        bout      <= bo_bit;
                        zero      <= (sd_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1, checked
// against plain integer subtraction.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, bout8, zero8;
    logic [7:0] diff8;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, bout1, zero1;
    logic [0:0] diff1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8),
        .out_ready(out_ready8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .diff(diff1), .bout(bout1), .zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned a - b - bin in plain integer arithmetic.
    task automatic ref8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output logic [7:0] dv, output logic bo);
        int e;
        e  = int'(av) - int'(bv) - int'(bi);
        dv = 8'(e);
        bo = (e < 0);
    endtask

    // Issue one operation, check latency and result, hold for bp cycles, release.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int bp);
        logic [7:0] ed;
        logic       eb;
        ref8(av, bv, bi, ed, eb);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready8), 32'd1);
        a8 = av; b8 = bv; bin8 = bi; in_valid8 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            in_valid8  = 1'($urandom);
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            bin8       = 1'($urandom);
            out_ready8 = 1'($urandom);
            check("run_out_valid", 32'(out_valid8), 32'd0);
            check("run_in_ready", 32'(in_ready8), 32'd0);
            @(negedge clk);
        end
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("done_out_valid", 32'(out_valid8), 32'd1);
        check("done_in_ready", 32'(in_ready8), 32'd0);
        check("diff", 32'(diff8), 32'(ed));
        check("bout", 32'(bout8), 32'(eb));
        check("zero", 32'(zero8), 32'(ed == 8'd0));
        for (int j = 0; j < bp; j++) begin
            in_valid8 = 1'($urandom);
            a8        = 8'($urandom);
            b8        = 8'($urandom);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid8), 32'd1);
            check("hold_in_ready", 32'(in_ready8), 32'd0);
            check("hold_diff", 32'(diff8), 32'(ed));
            check("hold_bout", 32'(bout8), 32'(eb));
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("release_out_valid", 32'(out_valid8), 32'd0);
        check("release_in_ready", 32'(in_ready8), 32'd1);
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic bi);
        int e;
        e = int'(av) - int'(bv) - int'(bi);
        @(negedge clk);
        a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("w1_run_out_valid", 32'(out_valid1), 32'd0);
        check("w1_run_in_ready", 32'(in_ready1), 32'd0);
        @(negedge clk);
        check("w1_out_valid", 32'(out_valid1), 32'd1);
        check("w1_diff", 32'(diff1), 32'(e & 1));
        check("w1_bout", 32'(bout1), 32'(e < 0));
        check("w1_zero", 32'(zero1), 32'((e & 1) == 0));
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        check("w1_release", 32'(in_ready1), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rbi;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready8), 32'd0);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_zero", 32'(zero8), 32'd0);
        rst = 1'b0;

        do_op8(8'h5A, 8'h3C, 1'b0, 0);
        do_op8(8'h10, 8'h20, 1'b0, 0);
        do_op8(8'h00, 8'h00, 1'b1, 0);
        do_op8(8'hFF, 8'hFF, 1'b0, 0);
        do_op8(8'h37, 8'hC2, 1'b1, 20);

        // Abandon an operation with reset on its fourth RUN edge.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_diff", 32'(diff8), 32'd0);
        check("midrst_bout", 32'(bout8), 32'd0);
        check("midrst_in_ready", 32'(in_ready8), 32'd0);
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(in_ready8), 32'd1);
        repeat (12) begin
            @(negedge clk);
            check("postrst_no_result", 32'(out_valid8), 32'd0);
        end
        do_op8(8'h03, 8'h01, 1'b0, 0);

        for (int i = 0; i < 8; i++)
            do_op1(1'(i >> 2), 1'(i >> 1), 1'(i));

        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbi = 1'($urandom);
            do_op8(ra, rb, rbi, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple subtractor: computes diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- Counterpart to the team's combinational full-adder cell; this is the subtract direction, built around a single-bit full-subtractor cell plus a borrow flip-flop.
- Sits behind a valid/ready operand interface and presents a held result with its own valid/ready handshake.
- Trades WIDTH cycles of latency for one-bit datapath area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 when a < b + bin (unsigned).
- zero  output  1  diff == 0; valid only while out_valid is high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - diff, bout, zero, out_valid go to 0.
  - Shift registers, borrow flip-flop and bit counter are cleared.
  - in_ready = (state==IDLE) && !rst, so it reads 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, load a into shift register sa, b into sb, bin into the borrow flip-flop, clear the counter, and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge:
    - d = sa[0] ^ sb[0] ^ br.
    - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
    - d shifts into the MSB of the result register sd, which shifts right.
    - sa and sb shift right.
    - The counter increments.
  - After the edge that processes bit WIDTH-1: latch bout = br_next, compute zero from the final sd, and go to DONE.
- Latency:
  - Operands are accepted at edge T.
  - out_valid is high starting the cycle after edge T+WIDTH, i.e. WIDTH cycles after acceptance.
  - For WIDTH=1, one RUN cycle.
- DONE:
  - out_valid=1; diff, bout, zero are stable.
  - in_ready=0; the block never accepts new operands while holding a result.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - out_ready=0 holds the result indefinitely.
- Throughput: at most one operation per WIDTH+2 cycles (accept, WIDTH bit cycles, handoff).
- Handshake rules:
  - in_valid and operands are sampled only when in_ready=1.
  - Changes to a, b, bin during RUN or DONE have no effect.
  - out_ready is ignored outside DONE.
- Reset mid-operation: an rst during RUN or DONE abandons the operation. No result is produced, and outputs follow the reset values.
- Width rules:
  - Counter width is CNT_W = max(1, $clog2(WIDTH)).
  - diff wraps modulo 2^WIDTH.
  - bout matches the borrow of a (WIDTH+1)-bit subtraction.

Decomposition:
- Package serial_sub_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the CNT_W helper function.
- Sub-module full_subtractor_bit: purely combinational, with inputs x, y, bi and outputs d, bo.
  - Instanced once in the datapath.
  - Mirrors the structure of the existing full-adder cell.
- The top level contains the FSM, shift registers, borrow flip-flop and counter.

Test Plan (WIDTH=8 unless stated):
- a=0x5A, b=0x3C, bin=0 -> after 8 cycles: out_valid=1, diff=0x1E, bout=0, zero=0.
- a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0, zero=1. Check in_ready=0 throughout RUN and DONE.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - diff and bout must stay stable.
  - in_valid pulses during this time are ignored.
  - After out_ready=1: IDLE, in_ready=1 the next cycle.
- Reset: assert rst on RUN cycle 4 of a=0x80, b=0x01.
  - Outputs go to 0 and state to IDLE.
  - The next operation, a=0x03, b=0x01, gives diff=0x02 with correct latency.
- WIDTH=1 build, all 8 input combinations -> diff and bout match the full-subtractor truth table with 1-cycle RUN latency; a random scoreboard with 1000 vectors passes at WIDTH=8.
